// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operation/result handshake bundle for pipe_adder
// Request side : in_valid, in_ready, a, b, ci, sub
// Result side  : out_valid, out_ready, s, co
// Flag outputs : ovf, zero (only when PIPE_ADDER_FLAGS_EN is defined)
// master = producer/consumer around the adder, slave = the adder itself.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef PIPE_ADDER_FLAGS_EN
  logic             ovf;
  logic             zero;
`endif

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
`ifdef PIPE_ADDER_FLAGS_EN
    input  ovf, zero,
`endif
    input  in_ready, out_valid, s, co
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
`ifdef PIPE_ADDER_FLAGS_EN
    output ovf, zero,
`endif
    output in_ready, out_valid, s, co
  );
endinterface

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined WIDTH-bit adder/subtractor, one SEG-bit ripple segment per stage
// Parameters : WIDTH (operand width, multiple of SEG), SEG (bits per stage)
// Ports      : clk, rst (async, active-high), bus (pipe_adder_if.slave)
//              bus request side  in_valid/in_ready/a/b/ci/sub
//              bus result side   out_valid/out_ready/s/co
// Option     : PIPE_ADDER_FLAGS_EN adds registered ovf/zero flags on bus.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic        clk,
  input  logic        rst,
  pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand-B bits arriving at this stage: segment k and everything above it.
    localparam int BW = WIDTH - k * SEG;

    logic             v_q;
    // Segments 0..k hold finished sums, segments above still hold operand A.
    logic [WIDTH-1:0] a_q;
    logic             c_q;

    logic             src_v;
    logic [WIDTH-1:0] src_a;
    logic [BW-1:0]    src_b;
    logic             src_c;
    logic             go;
    logic             en;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] a_nxt;

    if (k == 0) begin : g_src
      // Subtract is a + ~b + !ci, so invert B and the carry once at the entry.
      assign src_v = bus.in_valid;
      assign src_a = bus.a;
      assign src_b = bus.sub ? ~bus.b : bus.b;
      assign src_c = bus.sub ? ~bus.ci : bus.ci;
    end else begin : g_src
      assign src_v = g_stage[k-1].v_q;
      assign src_a = g_stage[k-1].a_q;
      assign src_b = g_stage[k-1].g_bq.b_q;
      assign src_c = g_stage[k-1].c_q;
    end

    // go = this stage's contents move on at the next edge.
    if (k == LAST) begin : g_go
      assign go = bus.out_ready;
    end else begin : g_go
      assign go = g_stage[k+1].en;
    end

    // An empty stage always loads, so bubbles collapse.
    assign en = !v_q || go;

    assign seg_sum = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[SEG-1:0]}
                   + {{SEG{1'b0}}, src_c};

    always_comb begin
      a_nxt               = src_a;
      a_nxt[k*SEG +: SEG] = seg_sum[SEG-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        a_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        v_q <= src_v;
        if (src_v) begin
          a_q <= a_nxt;
          c_q <= seg_sum[SEG];
        end
      end
    end

    // The last stage has no operand bits left to carry forward.
    if (k < LAST) begin : g_bq
      logic [BW-SEG-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_q <= '0;
        end else if (en && src_v) begin
          b_q <= src_b[BW-1:SEG];
        end
      end
    end
  end

  assign bus.in_ready  = g_stage[0].en;
  assign bus.out_valid = g_stage[LAST].v_q;
  assign bus.s         = g_stage[LAST].a_q;
  assign bus.co        = g_stage[LAST].c_q;

`ifdef PIPE_ADDER_FLAGS_EN
  // Sign bits of A and B' are still the raw operand MSBs when they reach the
  // last stage, so overflow is decided as the top segment is added.
  logic             ovf_q;
  logic             zero_q;
  logic             lst_a_msb;
  logic             lst_b_msb;
  logic [WIDTH-1:0] lst_sum;

  assign lst_a_msb = g_stage[LAST].src_a[WIDTH-1];
  assign lst_b_msb = g_stage[LAST].src_b[SEG-1];
  assign lst_sum   = g_stage[LAST].a_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (g_stage[LAST].en && g_stage[LAST].src_v) begin
      ovf_q  <= (lst_a_msb == lst_b_msb) && (lst_sum[WIDTH-1] != lst_a_msb);
      zero_q <= (lst_sum == '0);
    end
  end

  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder (WIDTH=16, SEG=4)
module tb_pipe_adder;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
  } op_t;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  pipe_adder_if #(.WIDTH(16)) bus ();

  pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: integer arithmetic on the operands, independent of segmenting.
  function automatic res_t model(input op_t op);
    res_t r;
    int   ua, ub, sa, sb, c, ur, sr;
    ua = op.a;
    ub = op.b;
    sa = $signed(op.a);
    sb = $signed(op.b);
    c  = op.ci;
    if (op.sub) begin
      ur   = ua - ub - c;
      sr   = sa - sb - c;
      r.co = (ur >= 0);
    end else begin
      ur   = ua + ub + c;
      sr   = sa + sb + c;
      r.co = (ur > 65535);
    end
    r.s    = ur[15:0];
    r.ovf  = (sr > 32767) || (sr < -32768);
    r.zero = (r.s == 16'h0000);
`ifndef PIPE_ADDER_FLAGS_EN
    r.ovf  = 1'b0;
    r.zero = 1'b0;
`endif
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.a   = 16'($urandom);
    op.b   = ($urandom_range(0, 3) == 0) ? ~op.a : 16'($urandom);
    op.ci  = 1'($urandom);
    op.sub = 1'($urandom);
    return op;
  endfunction

  // One clock: drive at negedge, sample 1ns later, return at the next negedge.
  task automatic cycle(input logic iv, input op_t op, input logic ordy,
                       output logic acc, output logic ov, output logic took,
                       output res_t got);
    bus.in_valid  = iv;
    bus.a         = op.a;
    bus.b         = op.b;
    bus.ci        = op.ci;
    bus.sub       = op.sub;
    bus.out_ready = ordy;
    #1;
    acc    = iv && bus.in_ready;
    ov     = bus.out_valid;
    took   = bus.out_valid && ordy;
    got.s  = bus.s;
    got.co = bus.co;
`ifdef PIPE_ADDER_FLAGS_EN
    got.ovf  = bus.ovf;
    got.zero = bus.zero;
`else
    got.ovf  = 1'b0;
    got.zero = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.s !== 16'h0000) $display("FAIL reset_s: got %h want 0000", bus.s); else n_pass++;
    n_total++; if (bus.co !== 1'b0) $display("FAIL reset_co: got %b want 0", bus.co); else n_pass++;
`ifdef PIPE_ADDER_FLAGS_EN
    n_total++; if (bus.ovf !== 1'b0 || bus.zero !== 1'b0) $display("FAIL reset_flags: got ovf=%b zero=%b want 0 0", bus.ovf, bus.zero); else n_pass++;
`endif
    rst = 1'b0;
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_directed();
    op_t  ops[3];
    res_t exp[3];
    res_t got;
    logic acc, ov, took;
    int   lat;
    ops[0] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, sub: 1'b0};
    exp[0] = '{s: 16'h0000, co: 1'b1, ovf: 1'b0, zero: 1'b1};
    ops[1] = '{a: 16'h0003, b: 16'h0005, ci: 1'b0, sub: 1'b1};
    exp[1] = '{s: 16'hFFFE, co: 1'b0, ovf: 1'b0, zero: 1'b0};
    ops[2] = '{a: 16'h8000, b: 16'h0001, ci: 1'b0, sub: 1'b1};
    exp[2] = '{s: 16'h7FFF, co: 1'b1, ovf: 1'b1, zero: 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, ops[i], 1'b1, acc, ov, took, got);
      n_total++; if (acc !== 1'b1) $display("FAIL directed_accept[%0d]: in_ready got %b want 1", i, acc); else n_pass++;
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        cycle(1'b0, ops[i], 1'b1, acc, ov, took, got);
        if (took) lat = c;
      end
      n_total++; if (lat !== 4) $display("FAIL directed_latency[%0d]: got %0d cycles want 4", i, lat); else n_pass++;
      n_total++; if (got.s !== exp[i].s || got.co !== exp[i].co) $display("FAIL directed_result[%0d]: got s=%h co=%b want s=%h co=%b", i, got.s, got.co, exp[i].s, exp[i].co); else n_pass++;
`ifdef PIPE_ADDER_FLAGS_EN
      n_total++; if (got.ovf !== exp[i].ovf || got.zero !== exp[i].zero) $display("FAIL directed_flags[%0d]: got ovf=%b zero=%b want ovf=%b zero=%b", i, got.ovf, got.zero, exp[i].ovf, exp[i].zero); else n_pass++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    res_t expq[$];
    res_t got, e;
    op_t  op;
    logic acc, ov, took, offer;
    int   first, last, n;
    first = -1; last = -1; n = 0;
    for (int c = 0; c < 16; c++) begin
      offer  = (c < 8);
      op.a   = 16'(c);
      op.b   = 16'(16'h0100 * c);
      op.ci  = c[0];
      op.sub = 1'b0;
      cycle(offer, op, 1'b1, acc, ov, took, got);
      if (took) begin
        if (first < 0) first = c;
        last = c;
        n++;
        n_total++;
        if (expq.size() == 0) $display("FAIL b2b_extra: unexpected result s=%h", got.s);
        else begin
          e = expq.pop_front();
          if (got !== e) $display("FAIL b2b_result[%0d]: got %h want %h", n - 1, got, e); else n_pass++;
        end
      end
      if (offer) begin
        n_total++; if (acc !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, acc); else n_pass++;
        if (acc) expq.push_back(model(op));
      end
    end
    n_total++; if (n !== 8 || first !== 4 || last !== 11) $display("FAIL b2b_timing: got n=%0d first=%0d last=%0d want 8 4 11", n, first, last); else n_pass++;
  endtask

  task automatic test_backpressure();
    op_t  ops[6];
    res_t expq[$];
    res_t got, held, e;
    logic acc, ov, took;
    int   idx;
    for (int i = 0; i < 6; i++) ops[i] = rand_op();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, ops[idx], 1'b0, acc, ov, took, got);
      if (acc) idx++;
      if (c == 4) held = got;
    end
    n_total++; if (idx !== 4) $display("FAIL bp_accepts: got %0d want 4", idx); else n_pass++;
    n_total++; if (ov !== 1'b1 || got !== model(ops[0])) $display("FAIL bp_head: got ov=%b %h want 1 %h", ov, got, model(ops[0])); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, ops[4], 1'b0, acc, ov, took, got);
      n_total++; if (acc !== 1'b0 || ov !== 1'b1 || got !== held) $display("FAIL bp_hold[%0d]: got acc=%b ov=%b %h want 0 1 %h", c, acc, ov, got, held); else n_pass++;
    end
    cycle(1'b1, ops[4], 1'b1, acc, ov, took, got);
    n_total++; if (took !== 1'b1 || got !== model(ops[0])) $display("FAIL bp_release_take: got took=%b %h want 1 %h", took, got, model(ops[0])); else n_pass++;
    n_total++; if (acc !== 1'b1) $display("FAIL bp_release_accept: got %b want 1", acc); else n_pass++;
    cycle(1'b1, ops[5], 1'b0, acc, ov, took, got);
    n_total++; if (acc !== 1'b0 || ov !== 1'b1 || got !== model(ops[1])) $display("FAIL bp_refull: got acc=%b ov=%b %h want 0 1 %h", acc, ov, got, model(ops[1])); else n_pass++;
    for (int i = 1; i < 5; i++) expq.push_back(model(ops[i]));
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, ops[5], 1'b1, acc, ov, took, got);
      if (took) begin
        n_total++;
        if (expq.size() == 0) $display("FAIL bp_extra: unexpected result s=%h", got.s);
        else begin
          e = expq.pop_front();
          if (got !== e) $display("FAIL bp_drain: got %h want %h", got, e); else n_pass++;
        end
      end
    end
    n_total++; if (expq.size() !== 0) $display("FAIL bp_missing: %0d results never appeared, want 0", expq.size()); else n_pass++;
  endtask

  task automatic test_bubbles();
    op_t  opa, opb, op;
    res_t got;
    res_t gotq[$];
    int   callq[$];
    logic acc, ov, took, offer;
    int   gap_valid;
    opa = rand_op();
    opb = rand_op();
    gap_valid = 0;
    for (int c = 0; c < 13; c++) begin
      offer = (c == 0) || (c == 4);
      op    = (c == 0) ? opa : opb;
      cycle(offer, op, 1'b1, acc, ov, took, got);
      if (offer) begin
        n_total++; if (acc !== 1'b1) $display("FAIL bubble_accept[%0d]: got %b want 1", c, acc); else n_pass++;
      end
      if (took) begin gotq.push_back(got); callq.push_back(c); end
      if (c >= 5 && c <= 7 && ov) gap_valid++;
    end
    n_total++; if (gotq.size() !== 2) $display("FAIL bubble_count: got %0d results want 2", gotq.size()); else n_pass++;
    if (gotq.size() == 2) begin
      n_total++; if (callq[0] !== 4 || gotq[0] !== model(opa)) $display("FAIL bubble_first: got cycle %0d %h want cycle 4 %h", callq[0], gotq[0], model(opa)); else n_pass++;
      n_total++; if (callq[1] !== 8 || gotq[1] !== model(opb)) $display("FAIL bubble_second: got cycle %0d %h want cycle 8 %h", callq[1], gotq[1], model(opb)); else n_pass++;
    end
    n_total++; if (gap_valid !== 0) $display("FAIL bubble_gap: out_valid high %0d times between results want 0", gap_valid); else n_pass++;
  endtask

  task automatic test_random();
    res_t q[$];
    res_t got, e;
    op_t  op;
    logic acc, ov, took, offer, ordy, pending;
    pending = 1'b0;
    offer   = 1'b0;
    op      = rand_op();
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        offer = ($urandom_range(0, 9) < 7);
        op    = rand_op();
      end
      ordy = ($urandom_range(0, 9) < 7);
      cycle(offer, op, ordy, acc, ov, took, got);
      if (took) begin
        n_total++;
        if (q.size() == 0) $display("FAIL rand_extra: unexpected result s=%h", got.s);
        else begin
          e = q.pop_front();
          if (got !== e) $display("FAIL rand_result[%0d]: got %h want %h", c, got, e); else n_pass++;
        end
      end
      if (acc) q.push_back(model(op));
      pending = offer && !acc;
      n_total++; if (q.size() > 4) $display("FAIL rand_occupancy: got %0d in flight want <= 4", q.size()); else n_pass++;
    end
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      cycle(1'b0, op, 1'b1, acc, ov, took, got);
      if (took) begin
        e = q.pop_front();
        n_total++; if (got !== e) $display("FAIL rand_drain: got %h want %h", got, e); else n_pass++;
      end
    end
    n_total++; if (q.size() !== 0) $display("FAIL rand_missing: %0d results never appeared, want 0", q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    op_t  op;
    res_t got;
    logic acc, ov, took;
    int   stale;
    for (int i = 0; i < 3; i++) begin
      op = '{a: 16'(16'h1234 + i), b: 16'h0101, ci: 1'b0, sub: 1'b0};
      cycle(1'b1, op, 1'b0, acc, ov, took, got);
    end
    cycle(1'b0, op, 1'b0, acc, ov, took, got);
    #1;
    n_total++; if (bus.out_valid !== 1'b1 || bus.s !== 16'h1335) $display("FAIL rstmid_pre: got ov=%b s=%h want 1 1335", bus.out_valid, bus.s); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.s !== 16'h0000 || bus.co !== 1'b0) $display("FAIL rstmid_s: got s=%h co=%b want 0000 0", bus.s, bus.co); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(negedge clk);
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, op, 1'b1, acc, ov, took, got);
      if (ov) stale++;
    end
    n_total++; if (stale !== 0) $display("FAIL rstmid_stale: out_valid seen %0d times want 0", stale); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined WIDTH-bit adder/subtractor built from SEG-bit ripple segments, with one register stage per segment and a valid/ready handshake on both sides. It is the datapath adder for the multi-cycle ALU and for address generation, where a full-width single-cycle ripple chain misses timing. It accepts one operation per cycle and holds its results under back-pressure.

## Interface
- WIDTH, 32: operand/result width; must be a non-zero multiple of SEG.
- SEG, 8: bits per pipeline segment; STAGES = WIDTH/SEG.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented on a/b/ci/sub.
- in_ready  out  1  the block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (add) or borrow-in (subtract).
- sub  in  1  0: add, 1: subtract.
- out_valid  out  1  s/co (and flags) valid.
- out_ready  in  1  consumer takes the result this cycle.
- s  out  WIDTH  result.
- co  out  1  carry-out; for subtract, 1 = no borrow.
- ovf, zero  out  1 each  present only with PIPE_ADDER_FLAGS_EN (see Configuration).

## Operation
- Add: {co,s} = a + b + ci. Subtract: {co,s} = a + ~b + !ci, i.e. a − b − ci, with co = NOT borrow.
- Transfer occurs on in_valid && in_ready; transfer out occurs on out_valid && out_ready.
- Stage k (0..STAGES−1) holds a valid bit v[k], the segment k sum plus the carry out of segment k, the already-computed lower segments, and the not-yet-added upper operand segments (b pre-inverted for subtract).
- Stage 0 adds a[SEG−1:0], b'[SEG−1:0] and the effective carry-in; stage k adds segment k using the registered carry from stage k−1.
- Stage k advances when v[k+1]==0 or stage k+1 advances; the last stage advances on out_ready. in_ready = !v[0] || stage 0 advances. The ready chain is combinational, giving full throughput with no bubbles.
- A stalled stage holds all of its contents unchanged. Bubbles collapse: an empty stage always accepts data from the stage before it.
- out_valid = v[STAGES−1]; s/co come straight from the last-stage registers.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.

## Timing
- Reset (async, anytime): all v[k]=0, out_valid=0, s=0, co=0, ovf=0, zero=0. in_ready=1 the first cycle after reset deassertion. In-flight operations are discarded.
- Latency: an operation accepted at edge n appears with out_valid=1 after edge n+STAGES−1 (STAGES cycles from acceptance to output registered). With STAGES=1 the result is valid the cycle after acceptance.
- Occupancy limit: STAGES operations. When full and out_ready=0, in_ready=0.
- Simultaneous input accept and output take while full: both occur in the same cycle and occupancy stays STAGES.
- Wrap-around: the result is modulo 2^WIDTH. The carry/borrow appears only on co.

## Configuration
- PIPE_ADDER_FLAGS_EN defined: the last stage also registers ovf = signed overflow, (a[MSB]==b'[MSB]) && (s[MSB]!=a[MSB]), and zero = (s==0). Both are valid with out_valid, 0 after reset, and held under stall. The sign bits are carried through the pipeline.
- Not defined: the ovf/zero ports and their logic are absent. All other behaviour is identical.

## Test plan
Bench configuration: WIDTH=16, SEG=4 (4 stages), out_ready=1 unless stated.

- Add with ripple across all segments: a=0xFFFF, b=0x0001, ci=0, sub=0 -> s=0x0000, co=1, out_valid 4 cycles after acceptance; zero=1 and ovf=0 with flags enabled.
- Subtract with borrow: a=0x0003, b=0x0005, ci=0, sub=1 -> s=0xFFFE, co=0. Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
- Back-to-back stream: 8 consecutive adds a=i, b=0x0100·i, ci=i[0] -> 8 results in order on 8 consecutive cycles, in_ready held at 1 throughout.
- Back-pressure: fill with 6 offers while out_ready=0 -> in_ready drops after 4 accepts and outputs are held stable; raising out_ready for 1 cycle -> exactly one result taken and one new operation accepted that same cycle.
- Bubbles: a single operation followed by 3 idle cycles, then a second operation -> each result arrives 4 cycles after its own acceptance, with out_valid low in between.
- Reset mid-operation: assert rst with 3 operations in flight -> out_valid=0 and s=0 immediately (asynchronous); after release, in_ready=1 and no stale result ever appears.
